// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared pipeline definitions for the forwarding controller.
//   FWD_* select codes driven onto the EX-stage 4:1 operand muxes:
//     FWD_RF     - register-file value
//     FWD_EXMEM  - EX/MEM result
//     FWD_MEMWB  - MEM/WB result
//     FWD_WBHOLD - WB-hold register (value retired the previous cycle)
//   sb_entry_t   - one scoreboard slot {valid, dst, is_load}
//   SB_ENTRY_W   - width of a scoreboard slot
//   sb_hit()     - true when a slot holds a pending write to a register
package pipe_pkg;

  localparam int REG_W      = 5;
  localparam int SB_ENTRY_W = 1 + REG_W + 1;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_EXMEM  = 2'b01;
  localparam logic [1:0] FWD_MEMWB  = 2'b10;
  localparam logic [1:0] FWD_WBHOLD = 2'b11;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
    logic             is_load;
  } sb_entry_t;

  // A slot matches a source register only while it carries a live write
  // to exactly that register.
  function automatic logic sb_hit(input sb_entry_t e, input logic [REG_W-1:0] r);
    return e.valid && (e.dst == r);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// fwd_sel
// Purely combinational operand-select generator for one EX operand mux.
// Ports:
//   src   - source register read by the ID-stage instruction
//   used  - the instruction really reads src
//   ex_e  - scoreboard slot of the instruction currently in EX
//   mem_e - scoreboard slot of the instruction currently in MEM
//   wb_e  - scoreboard slot of the instruction currently in WB
//   sel   - 2-bit select code for the consumer's EX cycle
module fwd_sel
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             used,
  input  sb_entry_t        ex_e,
  input  sb_entry_t        mem_e,
  input  sb_entry_t        wb_e,
  output logic [1:0]       sel
);

  // The nearest older writer holds the newest value, so the youngest slot
  // wins. Each slot moves one stage by the time the consumer reaches EX,
  // hence EX slot -> EX/MEM bypass, MEM slot -> MEM/WB bypass and WB slot
  // -> WB-hold register. Register 0 is hardwired and never forwarded.
  always_comb begin
    sel = FWD_RF;
    if (used && (src != '0)) begin
      if (sb_hit(ex_e, src)) begin
        sel = FWD_EXMEM;
      end else if (sb_hit(mem_e, src)) begin
        sel = FWD_MEMWB;
      end else if (sb_hit(wb_e, src)) begin
        sel = FWD_WBHOLD;
      end
    end
  end

endmodule

// File: rtl/fwd_ctrl.sv
// fwd_ctrl
// Forwarding and load-use hazard controller for a 5-stage pipeline.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   id_valid, id_rs, id_rt     - ID-stage instruction and its sources
//   id_rs_used, id_rt_used     - which sources the instruction reads
//   id_wreg, id_wdst           - the instruction writes register id_wdst
//   id_is_load                 - the instruction is a load
//   flush                      - kill the ID-stage instruction
//   hold                       - freeze the whole pipeline
//   fwd_a, fwd_b               - registered EX operand select codes (rs, rt)
//   stall                      - combinational load-use stall request
//   ex_bubble                  - registered: EX holds no instruction
//   stall_cnt                  - saturating count of stall cycles
module fwd_ctrl
  import pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_wreg,
  input  logic [REG_W-1:0] id_wdst,
  input  logic             id_is_load,
  input  logic             flush,
  input  logic             hold,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall,
  output logic             ex_bubble,
  output logic [31:0]      stall_cnt
);

  sb_entry_t  ex_e;
  sb_entry_t  mem_e;
  sb_entry_t  wb_e;
  sb_entry_t  id_e;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       use_a;
  logic       use_b;
  logic       kill;

  fwd_sel u_sel_a (
    .src   (id_rs),
    .used  (id_rs_used),
    .ex_e  (ex_e),
    .mem_e (mem_e),
    .wb_e  (wb_e),
    .sel   (sel_a)
  );

  fwd_sel u_sel_b (
    .src   (id_rt),
    .used  (id_rt_used),
    .ex_e  (ex_e),
    .mem_e (mem_e),
    .wb_e  (wb_e),
    .sel   (sel_b)
  );

  // A load's data is not available until the end of MEM, so a consumer
  // directly behind it must wait one cycle. Flush overrides the stall
  // (the consumer is gone anyway) and hold suppresses it since nothing
  // advances. During reset the EX slot is cleared, so stall stays low.
  always_comb begin
    use_a = id_rs_used && (id_rs != '0) && (ex_e.dst == id_rs);
    use_b = id_rt_used && (id_rt != '0) && (ex_e.dst == id_rt);
    stall = id_valid && !flush && !hold && ex_e.valid && ex_e.is_load &&
            (use_a || use_b);
  end

  // Scoreboard slot for the ID instruction; writes to register 0 are
  // discarded because nothing can ever consume them.
  always_comb begin
    id_e.valid   = id_wreg && (id_wdst != '0);
    id_e.dst     = id_wdst;
    id_e.is_load = id_is_load;
    kill         = stall || flush || !id_valid;
  end

  // Scoreboard shift and select-code registers advance together so the
  // codes line up with the consumer's EX cycle. A killed ID instruction
  // becomes a bubble in EX. hold freezes everything including the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_e      <= '0;
      mem_e     <= '0;
      wb_e      <= '0;
      fwd_a     <= FWD_RF;
      fwd_b     <= FWD_RF;
      ex_bubble <= 1'b1;
      stall_cnt <= '0;
    end else if (!hold) begin
      wb_e  <= mem_e;
      mem_e <= ex_e;
      if (kill) begin
        ex_e      <= '0;
        fwd_a     <= FWD_RF;
        fwd_b     <= FWD_RF;
        ex_bubble <= 1'b1;
      end else begin
        ex_e      <= id_e;
        fwd_a     <= sel_a;
        fwd_b     <= sel_b;
        ex_bubble <= 1'b0;
      end
      if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

endmodule
